multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the multicycle RV32I core; successor to the single-cycle controller.
//  Sequences fetch/decode/execute/memory/writeback over several cycles.
//  Supports a memory ready handshake, all six branch conditions, JALR, LUI and AUIPC, and an instret counter.
//  Sits between the instruction register and flag outputs of the datapath and its mux/enable controls.
// PARAMETERS
//  ALUCTRL_W  4   ALUControl width (>=4)
//  IMMSRC_W   3   ImmSrc width (>=3)
//  CNT_W      32  instret counter width
// PORTS
//  clk         in   1          clock, rising edge
//  reset       in   1          synchronous, active-high
//  opcode      in   7          IR[6:0]
//  funct3      in   3          IR[14:12]
//  funct7_5    in   1          IR[30]
//  Zero,Neg,Carry,Ovf in 1 each  ALU flags (Carry=1 means no borrow on sub)
//  mem_ready   in   1          memory completes the current access this cycle
//  mem_req     out  1          memory access request
//  AdrSrc      out  1          0=PC, 1=Result
//  IRWrite, PCWrite, RegWrite, MemWrite  out 1 each  write enables
//  ResultSrc   out  2          00=ALUOut, 01=Data, 10=ALUResult
//  ALUSrcA     out  2          00=PC, 01=OldPC, 10=RD1, 11=zero
//  ALUSrcB     out  2          00=RD2, 01=ImmExt, 10=const 4
//  ImmSrc      out  IMMSRC_W   000=I, 001=S, 010=B, 011=J, 100=U (combinational from opcode)
//  ALUControl  out  ALUCTRL_W  0 add,1 sub,2 and,3 or,4 xor,5 slt,6 sltu,7 sll,8 srl,9 sra
//  instret     out  CNT_W      retired-instruction count
//  illegal     out  1          only with ILLEGAL_TRAP_EN; else tied 0
// BEHAVIOUR
//  Moore outputs decode from the state; PCWrite = PCUpdate | (Branch & taken).
//  Reset: state<=FETCH, instret<=0; while reset=1, all write enables and mem_req are 0.
//  Reset in any state, including mid-handshake, abandons the instruction.
//  FETCH: mem_req=1, AdrSrc=0, A=00, B=10, add, ResultSrc=10. Hold until mem_ready.
//    IRWrite and PCWrite assert only in the mem_ready cycle, then go to DECODE.
//  DECODE: A=01, B=01, add (branch/JAL target to ALUOut). Next state by opcode:
//    0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH;
//    1101111 -> JAL; 1100111 -> JALRADR; 0110111 -> LUI; 0010111 -> AUIPC; other -> FETCH (nop)
//  MEMADR: A=10, B=01, add -> MEMREAD (op[5]=0) or MEMWRITE (op[5]=1)
//  MEMREAD: mem_req, AdrSrc=1, ResultSrc=00; wait mem_ready -> MEMWB
//  MEMWB: ResultSrc=01, RegWrite -> FETCH
//  MEMWRITE: mem_req, AdrSrc=1, ResultSrc=00; MemWrite=mem_ready; on ready -> FETCH
//  EXECR: A=10, B=00, R-op -> ALUWB
//  EXECI: A=10, B=01, I-op -> ALUWB
//  ALUWB: ResultSrc=00, RegWrite -> FETCH
//  BRANCH: A=10, B=00, sub, ResultSrc=00 -> FETCH. taken per funct3:
//    000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 !C; 111 C; 010/011 never taken
//  JALRADR: A=10, B=01, add -> JAL
//  JAL: A=01, B=10, add, ResultSrc=00, PCWrite -> ALUWB
//  LUI: A=11, B=01, add -> ALUWB.  AUIPC: A=01, B=01, add -> ALUWB
//  ALU decode for R/I ops: funct3 selects op. sub only when op[5]&funct7_5&funct3==000.
//    sra when funct3==101&funct7_5; I-type add never becomes sub.
//  instret increments by 1 on each transition into FETCH from a non-FETCH state; wraps at 2^CNT_W.
//  Unused outputs in a state are 0.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: unknown opcode in DECODE -> TRAP. TRAP holds, illegal=1,
//    all enables 0, instret frozen; exits only on reset.
//  ILLEGAL_TRAP_EN undefined: unknown opcode is a nop (DECODE->FETCH, counted); illegal=0.
// TESTING
//  reset, then add x3,x1,x2 with mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB; RegWrite in cycle 4; instret=1
//  lw with mem_ready low 3 cycles in MEMREAD -> mem_req held 4 cycles, MemWB RegWrite once; instret+1
//  bge, N=1, V=1 -> taken, PCWrite=1; blt same flags -> PCWrite=0; bltu C=0 -> PCWrite=1
//  jalr -> JALRADR,JAL(PCWrite=1),ALUWB(RegWrite=1); lui -> ALUSrcA=11
//  reset asserted in MEMWRITE with mem_ready=0 -> MemWrite never 1; FETCH next cycle; instret=0
//  opcode 0000000: with ILLEGAL_TRAP_EN -> illegal=1, state stuck; without -> FETCH, instret+1

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: fetch/decode/execute/memory/writeback with a memory ready handshake.
// Define ILLEGAL_TRAP_EN to send unknown opcodes to a sticky TRAP state; by default they retire as nops.
module multicycle_controller #(
  parameter int ALUCTRL_W = 4,
  parameter int IMMSRC_W  = 3,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 Zero,
  input  logic                 Neg,
  input  logic                 Carry,
  input  logic                 Ovf,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [IMMSRC_W-1:0]  ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [CNT_W-1:0]     instret,
  output logic                 illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JALRADR, S_JAL, S_LUI, S_AUIPC, S_TRAP
  } state_t;

  state_t     state, state_next;
  logic       pc_update, branch, taken, ir_write, reg_write, mem_write, req;
  logic [1:0] alu_op;
  logic [3:0] alu_code;
  logic [2:0] imm_code;

  // instret counts every return to FETCH, so a stalled fetch is never counted twice
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (state_next == S_FETCH && state != S_FETCH)
        instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    req        = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    alu_op     = 2'd0;
    case (state)
      S_FETCH: begin
        req       = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_update  = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALRADR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
          default:           state_next = S_TRAP;
`else
          default:           state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        req    = 1'b1;
        AdrSrc = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        req       = 1'b1;
        AdrSrc    = 1'b1;
        mem_write = mem_ready;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'd2;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = 2'd2;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'd1;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_JALRADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = S_JAL;
      end
      // Link value OldPC+4 is formed here while the PC takes the target held in ALUOut
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA    = 2'b11;
        ALUSrcB    = 2'b01;
        state_next = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        state_next = S_ALUWB;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = Neg ^ Ovf;
      3'b101:  taken = ~(Neg ^ Ovf);
      3'b110:  taken = ~Carry;
      3'b111:  taken = Carry;
      default: taken = 1'b0;
    endcase
  end

  // opcode[5] separates R-type from I-type, so addi with IR[30] set stays an add
  always_comb begin
    alu_code = 4'd0;
    case (alu_op)
      2'd1: alu_code = 4'd1;
      2'd2: begin
        case (funct3)
          3'b000: alu_code = (opcode[5] && funct7_5) ? 4'd1 : 4'd0;
          3'b001: alu_code = 4'd7;
          3'b010: alu_code = 4'd5;
          3'b011: alu_code = 4'd6;
          3'b100: alu_code = 4'd4;
          3'b101: alu_code = funct7_5 ? 4'd9 : 4'd8;
          3'b110: alu_code = 4'd3;
          3'b111: alu_code = 4'd2;
        endcase
      end
      default: alu_code = 4'd0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_STORE:         imm_code = 3'b001;
      OP_BRANCH:        imm_code = 3'b010;
      OP_JAL:           imm_code = 3'b011;
      OP_LUI, OP_AUIPC: imm_code = 3'b100;
      default:          imm_code = 3'b000;
    endcase
  end

  assign mem_req    = req & ~reset;
  assign IRWrite    = ir_write & ~reset;
  assign PCWrite    = (pc_update | (branch & taken)) & ~reset;
  assign RegWrite   = reg_write & ~reset;
  assign MemWrite   = mem_write & ~reset;
  assign ImmSrc     = IMMSRC_W'(imm_code);
  assign ALUControl = ALUCTRL_W'(alu_code);

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction cycle/enable counts against a spec-level model.
// A narrow instret counter is used so that wrap-around is reached quickly.
module tb_multicycle_controller;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, funct7_5, Zero, Neg, Carry, Ovf, mem_ready;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal;
  logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]       ImmSrc;
  logic [3:0]       ALUControl;
  logic [CNT_W-1:0] instret;

  int compared   = 0;
  int mismatched = 0;
  logic [CNT_W-1:0] exp_instret;

  always #5 clk = ~clk;

  multicycle_controller #(.ALUCTRL_W(4), .IMMSRC_W(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .Zero(Zero), .Neg(Neg), .Carry(Carry), .Ovf(Ovf), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instret(instret),
    .illegal(illegal)
  );

  // Branch outcome from the real comparison of the two operands
  function automatic logic exp_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Operation names: add0 sub1 and2 or3 xor4 slt5 sltu6 sll7 srl8 sra9
  function automatic logic [3:0] exp_alu(input logic is_r, input logic [2:0] f3, input logic f75);
    case (f3)
      3'b000:  return (is_r && f75) ? 4'd1 : 4'd0;
      3'b001:  return 4'd7;
      3'b010:  return 4'd5;
      3'b011:  return 4'd6;
      3'b100:  return 4'd4;
      3'b101:  return f75 ? 4'd9 : 4'd8;
      3'b110:  return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_instret = '0;
    #1;
  endtask

  // Runs one instruction from FETCH to the next FETCH; fw/mw are wait cycles for fetch and data access
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic [31:0] a, input logic [31:0] b, input int fw, input int mw);
    logic [31:0] diff;
    int post, exp_rw, exp_mw, exp_pc, exp_req, exp_cyc;
    logic is_mem, is_alu, is_r, want_a11;
    logic [2:0] exp_imm, imm_seen;
    logic [3:0] alu_seen;
    int cyc, n_ir, n_pc, n_rw, n_mw, n_req, rw_cyc, fwait, mwait;
    logic seen_ir, done, alu_got, a11_seen, ill_seen;

    diff = a - b;
    opcode = op; funct3 = f3; funct7_5 = f75;
    Zero = (diff == 32'd0);
    Neg = diff[31];
    Carry = (a >= b);
    Ovf = (a[31] != b[31]) && (diff[31] != a[31]);

    post = 1; exp_rw = 0; exp_mw = 0; exp_pc = 1; is_mem = 0; is_alu = 0; is_r = 0;
    want_a11 = 0; exp_imm = 3'b000;
    case (op)
      7'b0110011: begin post = 3; exp_rw = 1; is_alu = 1; is_r = 1; end
      7'b0010011: begin post = 3; exp_rw = 1; is_alu = 1; end
      7'b0000011: begin post = 4 + mw; exp_rw = 1; is_mem = 1; end
      7'b0100011: begin post = 3 + mw; exp_mw = 1; is_mem = 1; exp_imm = 3'b001; end
      7'b1100011: begin post = 2; exp_pc = 1 + int'(exp_taken(f3, a, b)); exp_imm = 3'b010; end
      7'b1101111: begin post = 3; exp_rw = 1; exp_pc = 2; exp_imm = 3'b011; end
      7'b1100111: begin post = 4; exp_rw = 1; exp_pc = 2; end
      7'b0110111: begin post = 3; exp_rw = 1; want_a11 = 1; exp_imm = 3'b100; end
      7'b0010111: begin post = 3; exp_rw = 1; exp_imm = 3'b100; end
      default: ;
    endcase
    exp_cyc = fw + 1 + post;
    exp_req = fw + 1 + (is_mem ? mw + 1 : 0);
    exp_instret = exp_instret + CNT_W'(1);

    cyc = 0; n_ir = 0; n_pc = 0; n_rw = 0; n_mw = 0; n_req = 0; rw_cyc = -1; fwait = 0; mwait = 0;
    seen_ir = 0; done = 0; alu_got = 0; a11_seen = 0; ill_seen = 0; alu_seen = 4'd0; imm_seen = 3'b000;
    while (!done && cyc < 60) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (mem_req && !AdrSrc && seen_ir) begin
        done = 1;
        mem_ready = 1'b0;
      end else begin
        if (mem_req) begin
          if (!AdrSrc) begin mem_ready = (fwait >= fw); fwait++; end
          else begin mem_ready = (mwait >= mw); mwait++; end
          #1;
        end
        if (cyc == 0) imm_seen = ImmSrc;
        if (IRWrite) begin n_ir++; seen_ir = 1; end
        if (PCWrite) n_pc++;
        if (RegWrite) begin n_rw++; rw_cyc = cyc; end
        if (MemWrite) n_mw++;
        if (mem_req) n_req++;
        if (illegal) ill_seen = 1;
        if (ALUSrcA == 2'b11) a11_seen = 1;
        if (ALUSrcA == 2'b10 && !alu_got) begin alu_got = 1; alu_seen = ALUControl; end
        cyc++;
      end
    end

    compared++;
    if (!done) begin
      mismatched++;
      $display("[TB] FAIL %s timeout: no return to FETCH within %0d cycles", name, cyc);
      apply_reset();
      return;
    end
    compared += 9;
    if (cyc !== exp_cyc) begin mismatched++; $display("[TB] FAIL %s cycles: got %0d expected %0d", name, cyc, exp_cyc); end
    if (n_ir !== 1) begin mismatched++; $display("[TB] FAIL %s IRWrite pulses: got %0d expected 1", name, n_ir); end
    if (n_pc !== exp_pc) begin mismatched++; $display("[TB] FAIL %s PCWrite pulses: got %0d expected %0d", name, n_pc, exp_pc); end
    if (n_rw !== exp_rw) begin mismatched++; $display("[TB] FAIL %s RegWrite pulses: got %0d expected %0d", name, n_rw, exp_rw); end
    if (n_mw !== exp_mw) begin mismatched++; $display("[TB] FAIL %s MemWrite pulses: got %0d expected %0d", name, n_mw, exp_mw); end
    if (n_req !== exp_req) begin mismatched++; $display("[TB] FAIL %s mem_req cycles: got %0d expected %0d", name, n_req, exp_req); end
    if (instret !== exp_instret) begin mismatched++; $display("[TB] FAIL %s instret: got %0d expected %0d", name, instret, exp_instret); end
    if (imm_seen !== exp_imm) begin mismatched++; $display("[TB] FAIL %s ImmSrc: got %b expected %b", name, imm_seen, exp_imm); end
    if (a11_seen !== want_a11) begin mismatched++; $display("[TB] FAIL %s ALUSrcA=11 seen: got %b expected %b", name, a11_seen, want_a11); end
    if (ill_seen !== 1'b0) begin
      compared++; mismatched++;
      $display("[TB] FAIL %s illegal: got 1 expected 0", name);
    end
    if (exp_rw == 1) begin
      compared++;
      if (rw_cyc !== exp_cyc - 1) begin mismatched++; $display("[TB] FAIL %s RegWrite cycle: got %0d expected %0d", name, rw_cyc, exp_cyc - 1); end
    end
    if (is_alu) begin
      compared++;
      if (alu_seen !== exp_alu(is_r, f3, f75)) begin
        mismatched++;
        $display("[TB] FAIL %s ALUControl: got %0d expected %0d", name, alu_seen, exp_alu(is_r, f3, f75));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
    Zero = 1'b0; Neg = 1'b0; Carry = 1'b0; Ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    compared++;
    if ({mem_req, IRWrite, PCWrite, RegWrite, MemWrite} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset enables: got %b expected 00000", {mem_req, IRWrite, PCWrite, RegWrite, MemWrite});
    end
    reset = 1'b0; mem_ready = 1'b0; exp_instret = '0;
    #1;
    compared += 3;
    if (instret !== '0) begin mismatched++; $display("[TB] FAIL reset instret: got %0d expected 0", instret); end
    if ({mem_req, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl} !== {2'b10, 2'b00, 2'b10, 2'b10, 4'd0}) begin
      mismatched++;
      $display("[TB] FAIL fetch controls: got %b expected 1000101000000", {mem_req, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl});
    end
    if ({IRWrite, PCWrite} !== 2'b00) begin mismatched++; $display("[TB] FAIL fetch wait enables: got %b expected 00", {IRWrite, PCWrite}); end
    mem_ready = 1'b1;
    #1;
    compared++;
    if ({IRWrite, PCWrite} !== 2'b11) begin mismatched++; $display("[TB] FAIL fetch ready enables: got %b expected 11", {IRWrite, PCWrite}); end
    mem_ready = 1'b0;
  endtask

  task automatic test_add();
    run_instr("add", 7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 0, 0);
  endtask

  task automatic test_load_wait();
    run_instr("lw_wait3", 7'b0000011, 3'b010, 1'b0, 32'd0, 32'd0, 0, 3);
    run_instr("sw_wait2", 7'b0100011, 3'b010, 1'b0, 32'd0, 32'd0, 1, 2);
  endtask

  task automatic test_branches();
    run_instr("bge_NV", 7'b1100011, 3'b101, 1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 0);
    run_instr("blt_NV", 7'b1100011, 3'b100, 1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 0);
    run_instr("bltu_C0", 7'b1100011, 3'b110, 1'b0, 32'd1, 32'd2, 0, 0);
    run_instr("beq_eq", 7'b1100011, 3'b000, 1'b0, 32'd9, 32'd9, 0, 0);
    run_instr("b010_never", 7'b1100011, 3'b010, 1'b0, 32'd9, 32'd9, 0, 0);
  endtask

  task automatic test_jumps_upper();
    run_instr("jalr", 7'b1100111, 3'b000, 1'b0, 32'd0, 32'd0, 0, 0);
    run_instr("jal", 7'b1101111, 3'b000, 1'b0, 32'd0, 32'd0, 2, 0);
    run_instr("lui", 7'b0110111, 3'b000, 1'b0, 32'd0, 32'd0, 0, 0);
    run_instr("auipc", 7'b0010111, 3'b000, 1'b0, 32'd0, 32'd0, 0, 0);
  endtask

  task automatic test_alu_decode();
    run_instr("sub", 7'b0110011, 3'b000, 1'b1, 32'd0, 32'd0, 0, 0);
    run_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 32'd0, 32'd0, 0, 0);
    run_instr("srai", 7'b0010011, 3'b101, 1'b1, 32'd0, 32'd0, 0, 0);
    run_instr("srl", 7'b0110011, 3'b101, 1'b0, 32'd0, 32'd0, 0, 0);
  endtask

  task automatic test_random();
    logic [6:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
`ifdef ILLEGAL_TRAP_EN
      case ($urandom_range(0, 8))
`else
      case ($urandom_range(0, 10))
`endif
        0: op = 7'b0110011;
        1: op = 7'b0010011;
        2: op = 7'b0000011;
        3: op = 7'b0100011;
        4: op = 7'b1100011;
        5: op = 7'b1101111;
        6: op = 7'b1100111;
        7: op = 7'b0110111;
        8: op = 7'b0010111;
        9: op = 7'b0001111;
        default: op = 7'b1111111;
      endcase
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      run_instr("random", op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), a, b,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
    int bad;
    bad = 0;
    opcode = 7'b0000000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      if (i >= 2 && (illegal !== 1'b1 || {mem_req, IRWrite, PCWrite, RegWrite, MemWrite} !== 5'b0)) bad++;
    end
    compared += 2;
    if (bad !== 0) begin mismatched++; $display("[TB] FAIL trap hold: got %0d bad cycles expected 0", bad); end
    if (instret !== exp_instret) begin mismatched++; $display("[TB] FAIL trap instret: got %0d expected %0d", instret, exp_instret); end
    apply_reset();
    compared++;
    if (illegal !== 1'b0) begin mismatched++; $display("[TB] FAIL trap exit: got illegal=%b expected 0", illegal); end
`else
    run_instr("nop_op0", 7'b0000000, 3'b000, 1'b0, 32'd0, 32'd0, 0, 0);
`endif
  endtask

  task automatic test_reset_in_store();
    int n;
    logic got;
    got = 0;
    n = 0;
    opcode = 7'b0100011;
    while (!got && n < 20) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (mem_req && AdrSrc) got = 1;
      else mem_ready = 1'b1;
      n++;
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("[TB] FAIL store access timeout: no data request within %0d cycles", n);
    end
    compared++;
    if (MemWrite !== 1'b0) begin mismatched++; $display("[TB] FAIL store wait MemWrite: got %b expected 0", MemWrite); end
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    compared++;
    if (MemWrite !== 1'b0) begin mismatched++; $display("[TB] FAIL reset-in-store MemWrite: got %b expected 0", MemWrite); end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    exp_instret = '0;
    #1;
    compared += 2;
    if ({mem_req, AdrSrc} !== 2'b10) begin mismatched++; $display("[TB] FAIL reset-in-store next state: got mem_req/AdrSrc=%b expected 10", {mem_req, AdrSrc}); end
    if (instret !== '0) begin mismatched++; $display("[TB] FAIL reset-in-store instret: got %0d expected 0", instret); end
    run_instr("after_reset_add", 7'b0110011, 3'b111, 1'b0, 32'd0, 32'd0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_branches();
    test_jumps_upper();
    test_alu_decode();
    test_random();
    test_illegal();
    test_reset_in_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
